// File: rtl/ed_sobel_window_if.sv
// rtl/ed_sobel_window_if.sv - pixel tap / edge result bundle for ed_sobel_window
interface ed_sobel_window_if #(
    parameter int PIX_W = 12,
    parameter int MAG_W = PIX_W + 3
);
    logic             enable;
    logic [PIX_W-1:0] row0_in;
    logic [PIX_W-1:0] row1_in;
    logic [PIX_W-1:0] row2_in;
    logic [8:0]       h_pos;
    logic [7:0]       v_pos;
    logic [MAG_W-1:0] threshold;
    logic             out_valid;
    logic             edge_out;
    logic [MAG_W-1:0] mag_out;
    logic [8:0]       out_h;
    logic [7:0]       out_v;
    logic             frame_done;
    logic [16:0]      edge_count;

    modport master (
        output enable, row0_in, row1_in, row2_in, h_pos, v_pos, threshold,
        input  out_valid, edge_out, mag_out, out_h, out_v, frame_done, edge_count
    );

    modport slave (
        input  enable, row0_in, row1_in, row2_in, h_pos, v_pos, threshold,
        output out_valid, edge_out, mag_out, out_h, out_v, frame_done, edge_count
    );
endinterface

// File: rtl/ed_sobel_window.sv
// rtl/ed_sobel_window.sv - 3x3 Sobel window, thresholded edge bit and per-frame edge count
module ed_sobel_window #(
    parameter int PIX_W  = 12,
    parameter int H_SIZE = 320,
    parameter int V_SIZE = 240
) (
    input  logic             clk,
    input  logic             reset,
    ed_sobel_window_if.slave pix
);
    localparam int MAG_W = PIX_W + 3;
    localparam int SUM_W = PIX_W + 2;

    // Window: win[row][col], row 0 = newest line (bottom), col 0 = newest column.
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] row_in [3];

    logic             s0_valid;
    logic [8:0]       s0_h;
    logic [7:0]       s0_v;

    logic                    s1_valid;
    logic signed [MAG_W-1:0] s1_gx;
    logic signed [MAG_W-1:0] s1_gy;
    logic [8:0]              s1_h;
    logic [7:0]              s1_v;
    logic                    s1_border;

    logic [16:0]      run_count;

    logic             qualify;
    logic [SUM_W-1:0] col_new, col_old, row_top, row_bot;
    logic signed [MAG_W-1:0] gx_c, gy_c;
    logic [MAG_W-1:0] mag_c;
    logic             edge_c;
    logic             last_c;

    function automatic logic [SUM_W-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b,
                                                  input logic [PIX_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    function automatic logic [MAG_W-1:0] abs_val(input logic signed [MAG_W-1:0] x);
        return x[MAG_W-1] ? MAG_W'(-x) : MAG_W'(x);
    endfunction

    // Gather the three vertical taps so the window shift can loop over rows.
    always_comb begin
        row_in[0] = pix.row0_in;
        row_in[1] = pix.row1_in;
        row_in[2] = pix.row2_in;
    end

    // Stage 0: shift the window on each pixel strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (pix.enable) begin
            for (int r = 0; r < 3; r++) begin
                win[r][2] <= win[r][1];
                win[r][1] <= win[r][0];
                win[r][0] <= row_in[r];
            end
        end
    end

    // Only positions whose window centre lies inside the frame produce a result.
    always_comb begin
        qualify = pix.enable
                  && (pix.h_pos >= 9'd2) && (pix.h_pos <= 9'(H_SIZE))
                  && (pix.v_pos >= 8'd2) && (pix.v_pos <= 8'(V_SIZE));
    end

    // Stage 0: tag the freshly shifted window with its centre position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_valid <= 1'b0;
            s0_h     <= '0;
            s0_v     <= '0;
        end else begin
            s0_valid <= qualify;
            if (qualify) begin
                s0_h <= pix.h_pos - 9'd1;
                s0_v <= pix.v_pos - 8'd1;
            end
        end
    end

    // Weighted column/row sums and the two signed gradients.
    always_comb begin
        col_new = tap_sum(win[0][0], win[1][0], win[2][0]);
        col_old = tap_sum(win[0][2], win[1][2], win[2][2]);
        row_top = tap_sum(win[2][0], win[2][1], win[2][2]);
        row_bot = tap_sum(win[0][0], win[0][1], win[0][2]);
        gx_c    = $signed({1'b0, col_new}) - $signed({1'b0, col_old});
        gy_c    = $signed({1'b0, row_top}) - $signed({1'b0, row_bot});
    end

    // Stage 1: register gradients; first column/line windows straddle stale data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s1_h      <= '0;
            s1_v      <= '0;
            s1_border <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_gx     <= gx_c;
                s1_gy     <= gy_c;
                s1_h      <= s0_h;
                s1_v      <= s0_v;
                s1_border <= (s0_h == 9'd1) || (s0_v == 8'd1);
            end
        end
    end

    // Magnitude, edge decision and last-centre detection.
    always_comb begin
        mag_c  = s1_border ? '0 : abs_val(s1_gx) + abs_val(s1_gy);
        edge_c = !s1_border && (mag_c > pix.threshold);
        last_c = (s1_h == 9'(H_SIZE - 1)) && (s1_v == 8'(V_SIZE - 1));
    end

    // Stage 2: emit the result and maintain the per-frame edge count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix.out_valid  <= 1'b0;
            pix.edge_out   <= 1'b0;
            pix.mag_out    <= '0;
            pix.out_h      <= '0;
            pix.out_v      <= '0;
            pix.frame_done <= 1'b0;
            pix.edge_count <= '0;
            run_count      <= '0;
        end else begin
            pix.out_valid  <= s1_valid;
            pix.frame_done <= 1'b0;
            if (s1_valid) begin
                pix.edge_out <= edge_c;
                pix.mag_out  <= mag_c;
                pix.out_h    <= s1_h;
                pix.out_v    <= s1_v;
                if (last_c) begin
                    pix.frame_done <= 1'b1;
                    pix.edge_count <= run_count + 17'(edge_c);
                    run_count      <= '0;
                end else begin
                    run_count <= run_count + 17'(edge_c);
                end
            end
        end
    end
endmodule

// File: tb/tb_ed_sobel_window.sv
// tb/tb_ed_sobel_window.sv - randomized self-checking bench for ed_sobel_window
module tb_ed_sobel_window;
    localparam int PIX_W = 12;
    localparam int MAG_W = PIX_W + 3;
    localparam int H     = 16;
    localparam int V     = 12;
    localparam int STEP_EDGES = 2 * (V - 2);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ed_sobel_window_if #(.PIX_W(PIX_W)) pix ();

    ed_sobel_window #(.PIX_W(PIX_W), .H_SIZE(H), .V_SIZE(V)) dut (
        .clk   (clk),
        .reset (reset),
        .pix   (pix)
    );

    typedef struct {
        int due;
        int h;
        int v;
        int mag;
        bit e;
        bit fd;
    } res_t;

    typedef struct {
        bit en;
        bit rst;
        int h;
        int v;
    } stim_t;

    int vectors = 0;
    int miscompares = 0;

    logic [PIX_W-1:0] img [0:V][1:H];
    int   thr;
    res_t expq[$];
    int   exp_run, exp_ec;
    int   last_mag, last_h, last_v;
    bit   last_e;
    int   obs_valid, obs_edges, obs_done;

    // Sobel magnitude straight from the image; line 0 of img is never read here.
    function automatic int sobel_mag(input int cx, input int cy);
        int gx, gy, w;
        if (cx == 1 || cy == 1) return 0;
        gx = 0;
        gy = 0;
        for (int d = -1; d <= 1; d++) begin
            w = (d == 0) ? 2 : 1;
            gx += w * (int'(img[cy+d][cx+1]) - int'(img[cy+d][cx-1]));
            gy += w * (int'(img[cy-1][cx+d]) - int'(img[cy+1][cx+d]));
        end
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    task automatic fill_image(input int kind, input int val);
        for (int v = 0; v <= V; v++) begin
            for (int h = 1; h <= H; h++) begin
                if (v == 0)        img[v][h] = PIX_W'($urandom);
                else if (kind == 0) img[v][h] = PIX_W'(val);
                else if (kind == 1) img[v][h] = (h > H / 2) ? 12'hFFF : 12'h000;
                else if (kind == 2) img[v][h] = PIX_W'($urandom);
                else               img[v][h] = (v == 1 && h == 1) ? 12'hFFF : 12'h000;
            end
        end
    endtask

    task automatic stream_frame(input int gap, input bit rand_gap, input int abort_v);
        stim_t st[$];
        stim_t s;
        res_t  r;
        int    c;
        logic [51:0] got, want;
        bit    aborted;
        aborted = 1'b0;
        for (int v = 1; v <= V && !aborted; v++) begin
            for (int h = 1; h <= H && !aborted; h++) begin
                if (abort_v != 0 && v == abort_v) begin
                    st.push_back('{en: 1'b0, rst: 1'b1, h: 0, v: 0});
                    st.push_back('{en: 1'b0, rst: 1'b1, h: 0, v: 0});
                    aborted = 1'b1;
                end else begin
                    st.push_back('{en: 1'b1, rst: 1'b0, h: h, v: v});
                    repeat (rand_gap ? $urandom_range(0, gap) : gap)
                        st.push_back('{en: 1'b0, rst: 1'b0, h: $urandom_range(0, 511), v: $urandom_range(0, 255)});
                end
            end
        end
        repeat (5) st.push_back('{en: 1'b0, rst: 1'b0, h: 0, v: 0});
        obs_valid = 0;
        obs_edges = 0;
        obs_done  = 0;
        c = 0;
        pix.threshold = MAG_W'(thr);
        foreach (st[i]) begin
            s = st[i];
            reset      = !s.rst;
            pix.enable = s.en;
            pix.h_pos  = 9'(s.h);
            pix.v_pos  = 8'(s.v);
            if (s.en) begin
                pix.row0_in = img[s.v][s.h];
                pix.row1_in = img[s.v-1][s.h];
                pix.row2_in = img[(s.v >= 3) ? s.v - 2 : 0][s.h];
                if (s.h >= 2 && s.v >= 2) begin
                    r.due = c + 3;
                    r.h   = s.h - 1;
                    r.v   = s.v - 1;
                    r.mag = sobel_mag(r.h, r.v);
                    r.e   = r.mag > thr;
                    r.fd  = (r.h == H - 1) && (r.v == V - 1);
                    expq.push_back(r);
                end
            end else begin
                pix.row0_in = PIX_W'($urandom);
                pix.row1_in = PIX_W'($urandom);
                pix.row2_in = PIX_W'($urandom);
            end
            if (s.rst) begin
                expq.delete();
                exp_run  = 0;
                exp_ec   = 0;
                last_mag = 0;
                last_h   = 0;
                last_v   = 0;
                last_e   = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
            if (expq.size() > 0 && expq[0].due == c) begin
                r = expq.pop_front();
                last_mag = r.mag;
                last_h   = r.h;
                last_v   = r.v;
                last_e   = r.e;
                if (r.fd) begin
                    exp_ec  = exp_run + int'(r.e);
                    exp_run = 0;
                end else begin
                    exp_run += int'(r.e);
                end
                want = {1'b1, r.e, MAG_W'(last_mag), 9'(last_h), 8'(last_v), r.fd, 17'(exp_ec)};
            end else begin
                want = {1'b0, last_e, MAG_W'(last_mag), 9'(last_h), 8'(last_v), 1'b0, 17'(exp_ec)};
            end
            got = {pix.out_valid, pix.edge_out, pix.mag_out, pix.out_h, pix.out_v,
                   pix.frame_done, pix.edge_count};
            obs_valid += int'(pix.out_valid);
            obs_edges += int'(pix.out_valid && pix.edge_out);
            obs_done  += int'(pix.frame_done);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL cycle_outputs c=%0d got{vld,edge,mag,h,v,fd,cnt}=%h want=%h", c, got, want);
            end
        end
        pix.enable = 1'b0;
        reset      = 1'b1;
        vectors++;
        if (expq.size() !== 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", expq.size());
            expq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pix.enable = 1'b1;
        pix.h_pos = 9'd5;
        pix.v_pos = 8'd5;
        pix.threshold = '0;
        pix.row0_in = 12'hFFF;
        pix.row1_in = 12'h000;
        pix.row2_in = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pix.out_valid, pix.edge_out, pix.mag_out, pix.out_h, pix.out_v,
             pix.frame_done, pix.edge_count} !== 52'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got vld=%b mag=%0d cnt=%0d want all 0",
                     pix.out_valid, pix.mag_out, pix.edge_count);
        end
        pix.enable = 1'b0;
        reset = 1'b1;
        exp_run = 0; exp_ec = 0;
        last_mag = 0; last_h = 0; last_v = 0; last_e = 1'b0;
    endtask

    task automatic test_uniform();
        fill_image(0, 12'h800);
        thr = 0;
        stream_frame(0, 1'b0, 0);
        vectors++;
        if (obs_valid !== (H - 1) * (V - 1) || obs_edges !== 0 || obs_done !== 1) begin
            miscompares++;
            $display("FAIL uniform valid=%0d edges=%0d done=%0d want %0d/0/1",
                     obs_valid, obs_edges, obs_done, (H - 1) * (V - 1));
        end
    endtask

    task automatic test_step(input int t, input int want_edges, input int gap);
        fill_image(1, 0);
        thr = t;
        stream_frame(gap, 1'b0, 0);
        vectors++;
        if (pix.edge_count !== 17'(want_edges) || obs_done !== 1) begin
            miscompares++;
            $display("FAIL step thr=%0d gap=%0d edge_count=%0d done=%0d want %0d/1",
                     t, gap, pix.edge_count, obs_done, want_edges);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_image(1, 0);
        thr = 1000;
        stream_frame(0, 1'b0, V / 2);
        vectors++;
        if (obs_done !== 0 || pix.edge_count !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_mid done=%0d edge_count=%0d want 0/0", obs_done, pix.edge_count);
        end
        test_step(1000, STEP_EDGES, 0);
    endtask

    task automatic test_border();
        fill_image(3, 0);
        thr = 0;
        stream_frame(0, 1'b0, 0);
        vectors++;
        if (pix.edge_count !== 17'd1) begin
            miscompares++;
            $display("FAIL border edge_count=%0d want 1", pix.edge_count);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 3; f++) begin
            fill_image(2, 0);
            thr = $urandom_range(0, 20000);
            stream_frame(2, 1'b1, 0);
            vectors++;
            if (obs_done !== 1) begin
                miscompares++;
                $display("FAIL random_done frame=%0d done=%0d want 1", f, obs_done);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        pix.enable = 1'b0;
        pix.row0_in = '0;
        pix.row1_in = '0;
        pix.row2_in = '0;
        pix.h_pos = '0;
        pix.v_pos = '0;
        pix.threshold = '0;
        test_reset();
        test_uniform();
        test_step(1000, STEP_EDGES, 0);
        test_step(16380, 0, 0);
        test_step(16379, STEP_EDGES, 0);
        test_step(1000, STEP_EDGES, 2);
        test_reset_mid_frame();
        test_border();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
